// File: rtl/sram_1rw1r_ctrl.sv
// Valid/ready front end for a 1rw1r SRAM macro: channel A read/write on port 0, channel B read on port 1.
// Optional macro SRAM_RAW_FWD_EN forwards same-cycle A-write data to a B read instead of stalling B.
module sram_1rw1r_ctrl #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    a_req_valid,
    output logic                    a_req_ready,
    input  logic                    a_req_we,
    input  logic [ADDR_WIDTH-1:0]   a_req_addr,
    input  logic [DATA_WIDTH/8-1:0] a_req_wmask,
    input  logic [DATA_WIDTH-1:0]   a_req_wdata,
    output logic                    a_rsp_valid,
    input  logic                    a_rsp_ready,
    output logic [DATA_WIDTH-1:0]   a_rsp_rdata,

    input  logic                    b_req_valid,
    output logic                    b_req_ready,
    input  logic [ADDR_WIDTH-1:0]   b_req_addr,
    output logic                    b_rsp_valid,
    input  logic                    b_rsp_ready,
    output logic [DATA_WIDTH-1:0]   b_rsp_rdata,

    output logic                    sram_csb0,
    output logic                    sram_web0,
    output logic [DATA_WIDTH/8-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0]   sram_addr0,
    output logic [DATA_WIDTH-1:0]   sram_din0,
    input  logic [DATA_WIDTH-1:0]   sram_dout0,
    output logic                    sram_csb1,
    output logic [ADDR_WIDTH-1:0]   sram_addr1,
    input  logic [DATA_WIDTH-1:0]   sram_dout1
);

    localparam int unsigned NUM_LANES = DATA_WIDTH / 8;
    localparam int unsigned PTR_W     = $clog2(RSP_DEPTH);
    localparam int unsigned CNT_W     = $clog2(RSP_DEPTH + 1);
    localparam int unsigned USED_W    = CNT_W + 1;

    // ------------------------------------------------------------------
    // Channel A state
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] a_buf_q [RSP_DEPTH];
    logic [PTR_W-1:0]      a_wptr_q, a_rptr_q;
    logic [CNT_W-1:0]      a_cnt_q, a_cnt_d;
    logic                  a_inflight_q;
    logic [USED_W-1:0]     a_used;
    logic                  a_acc, a_rd_acc, a_push, a_pop;

    // ------------------------------------------------------------------
    // Channel B state
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] b_buf_q [RSP_DEPTH];
    logic [PTR_W-1:0]      b_wptr_q, b_rptr_q;
    logic [CNT_W-1:0]      b_cnt_q, b_cnt_d;
    logic                  b_inflight_q;
    logic [USED_W-1:0]     b_used;
    logic                  b_credit, b_acc, b_push, b_pop;
    logic [DATA_WIDTH-1:0] b_push_data;

    logic                  raw_hit;

    // Credit counts both buffered words and the read whose data lands next edge.
    assign a_used      = USED_W'(a_cnt_q) + USED_W'(a_inflight_q);
    assign b_used      = USED_W'(b_cnt_q) + USED_W'(b_inflight_q);
    assign a_req_ready = ~rst & (a_used < USED_W'(RSP_DEPTH));
    assign b_credit    = ~rst & (b_used < USED_W'(RSP_DEPTH));

    assign a_acc    = a_req_valid & a_req_ready;
    assign a_rd_acc = a_acc & ~a_req_we;
    assign b_acc    = b_req_valid & b_req_ready;

    assign raw_hit  = a_acc & a_req_we & b_req_valid & (a_req_addr == b_req_addr);

    assign a_push      = a_inflight_q;
    assign a_rsp_valid = (a_cnt_q != '0);
    assign a_pop       = a_rsp_valid & a_rsp_ready;
    assign a_rsp_rdata = a_buf_q[a_rptr_q];

    assign b_push      = b_inflight_q;
    assign b_rsp_valid = (b_cnt_q != '0);
    assign b_pop       = b_rsp_valid & b_rsp_ready;
    assign b_rsp_rdata = b_buf_q[b_rptr_q];

    // ------------------------------------------------------------------
    // Macro drive
    // ------------------------------------------------------------------
    assign sram_csb0   = ~a_acc;
    assign sram_web0   = ~a_req_we;
    assign sram_wmask0 = a_req_wmask;
    assign sram_addr0  = a_req_addr;
    assign sram_din0   = a_req_wdata;
    assign sram_csb1   = ~b_acc;
    assign sram_addr1  = b_req_addr;

`ifdef SRAM_RAW_FWD_EN
    logic                  fwd_q;
    logic [DATA_WIDTH-1:0] fwd_wdata_q;
    logic [NUM_LANES-1:0]  fwd_wmask_q;

    assign b_req_ready = b_credit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_q       <= 1'b0;
            fwd_wdata_q <= '0;
            fwd_wmask_q <= '0;
        end else begin
            fwd_q <= raw_hit & b_acc;
            if (raw_hit & b_acc) begin
                fwd_wdata_q <= a_req_wdata;
                fwd_wmask_q <= a_req_wmask;
            end
        end
    end

    // The macro may return pre-write data for the hazard read; patch in written lanes.
    always_comb begin
        b_push_data = sram_dout1;
        if (fwd_q) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (fwd_wmask_q[i]) begin
                    b_push_data[8*i +: 8] = fwd_wdata_q[8*i +: 8];
                end
            end
        end
    end
`else
    // Stall B for one cycle so it reads after the write has landed.
    assign b_req_ready = b_credit & ~raw_hit;
    assign b_push_data = sram_dout1;
`endif

    // ------------------------------------------------------------------
    // Count next-state
    // ------------------------------------------------------------------
    always_comb begin
        a_cnt_d = a_cnt_q;
        case ({a_push, a_pop})
            2'b10:   a_cnt_d = a_cnt_q + CNT_W'(1);
            2'b01:   a_cnt_d = a_cnt_q - CNT_W'(1);
            default: a_cnt_d = a_cnt_q;
        endcase
    end

    always_comb begin
        b_cnt_d = b_cnt_q;
        case ({b_push, b_pop})
            2'b10:   b_cnt_d = b_cnt_q + CNT_W'(1);
            2'b01:   b_cnt_d = b_cnt_q - CNT_W'(1);
            default: b_cnt_d = b_cnt_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Channel A response buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt_q      <= '0;
            a_wptr_q     <= '0;
            a_rptr_q     <= '0;
            a_inflight_q <= 1'b0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                a_buf_q[i] <= '0;
            end
        end else begin
            a_inflight_q <= a_rd_acc;
            a_cnt_q      <= a_cnt_d;
            if (a_push) begin
                a_buf_q[a_wptr_q] <= sram_dout0;
                a_wptr_q          <= a_wptr_q + PTR_W'(1);
            end
            if (a_pop) begin
                a_rptr_q <= a_rptr_q + PTR_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Channel B response buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_cnt_q      <= '0;
            b_wptr_q     <= '0;
            b_rptr_q     <= '0;
            b_inflight_q <= 1'b0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                b_buf_q[i] <= '0;
            end
        end else begin
            b_inflight_q <= b_acc;
            b_cnt_q      <= b_cnt_d;
            if (b_push) begin
                b_buf_q[b_wptr_q] <= b_push_data;
                b_wptr_q          <= b_wptr_q + PTR_W'(1);
            end
            if (b_pop) begin
                b_rptr_q <= b_rptr_q + PTR_W'(1);
            end
        end
    end

endmodule
